systolic_mat_mult_nxn: RTL

- Parametrised NxN output-stationary systolic matrix multiplier top: C = A·B, with A (NxN) and B (NxN) streamed in N beats each.
- Successor to the fixed 8x8 top. Adds independent A/B handshakes with N-deep operand buffers, so A and B may arrive in any order.
- Adds signed/unsigned operand mode, accumulate-onto-previous-result mode for K-tiling, and a backpressured row drain.
- Sits between the operand/result buffer subsystem and the accelerator datapath.

---
 rtl/systolic_pkg.sv | 22 ++
 rtl/systolic_pe.sv | 59 +++++
 rtl/systolic_mat_mult_nxn.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the NxN systolic matrix multiplier.
//   state_e        : top-level control FSM states
//   cnt_w()        : width of a counter that must hold the values 0..n
//   DEF_*_WIDTH    : default operand / accumulator widths
package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ACC_WIDTH  = 32;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One multiply-accumulate cell of the output-stationary array.
//   clk, rst        : clock, asynchronous active-low reset
//   en              : accumulate this cycle's product
//   clr             : discard the old sum and load this cycle's product
//   signed_mode     : 1 = sign-extend operands, 0 = zero-extend
//   a_in / a_out    : A operand from the left, registered copy to the right
//   b_in / b_out    : B operand from above, registered copy downwards
//   acc_out         : running sum, wraps modulo 2^ACC_WIDTH
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  signed_mode,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic [ACC_WIDTH-1:0]  acc_out
);

  logic [DATA_WIDTH-1:0]       a_q, b_q;
  logic signed [ACC_WIDTH-1:0] a_ext, b_ext, prod, acc_q, acc_d;

  always_comb begin
    a_ext = {{(ACC_WIDTH-DATA_WIDTH){signed_mode & a_in[DATA_WIDTH-1]}}, a_in};
    b_ext = {{(ACC_WIDTH-DATA_WIDTH){signed_mode & b_in[DATA_WIDTH-1]}}, b_in};
    // Full-width product truncated to ACC_WIDTH: modulo arithmetic is the
    // same for signed and unsigned once the operands are extended.
    prod  = a_ext * b_ext;
    acc_d = acc_q;
    // Only PE(0,0) can see a non-zero operand on the clear cycle; loading
    // its product keeps beat 0 while dropping the previous result.
    if (clr)     acc_d = prod;
    else if (en) acc_d = acc_q + prod;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_in;
      b_q   <= b_in;
      acc_q <= acc_d;
    end
  end

  assign a_out   = a_q;
  assign b_out   = b_q;
  assign acc_out = acc_q;

endmodule

// File: rtl/systolic_mat_mult_nxn.sv
// NxN output-stationary systolic multiplier, C = A*B.
//   start/acc_mode/signed_mode/ready/done : operation control
//   a_valid/a_ready/a_in : A beats, beat k carries column k (a_in[i]=A[i][k])
//   b_valid/b_ready/b_in : B beats, beat k carries row k    (b_in[j]=B[k][j])
//   c_valid/c_ready/c_out/c_row : backpressured drain of C, one row per beat
// A and B are buffered independently; compute starts once both are full.
module systolic_mat_mult_nxn
  import systolic_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          acc_mode,
  input  logic                          signed_mode,
  output logic                          ready,
  output logic                          done,
  input  logic                          a_valid,
  output logic                          a_ready,
  input  logic [N-1:0][DATA_WIDTH-1:0]  a_in,
  input  logic                          b_valid,
  output logic                          b_ready,
  input  logic [N-1:0][DATA_WIDTH-1:0]  b_in,
  output logic                          c_valid,
  input  logic                          c_ready,
  output logic [N-1:0][ACC_WIDTH-1:0]   c_out,
  output logic [$clog2(N)-1:0]          c_row
);

  localparam int CW  = cnt_w(N);
  localparam int IW  = $clog2(N);
  localparam int CCW = cnt_w(3*N);
  localparam logic [CW-1:0]  N_CNT    = CW'(N);
  localparam logic [CCW-1:0] CC_LAST  = CCW'(3*N-3);
  localparam logic [IW-1:0]  ROW_LAST = IW'(N-1);

  state_e                         state_q, state_d;
  logic [CW-1:0]                  a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [CCW-1:0]                 cc_q, cc_d;
  logic [IW-1:0]                  row_q, row_d;
  logic                           acc_mode_q, acc_mode_d, signed_mode_q, signed_mode_d;
  logic [N-1:0][DATA_WIDTH-1:0]   a_buf_q [N], a_buf_d [N];
  logic [N-1:0][DATA_WIDTH-1:0]   b_buf_q [N], b_buf_d [N];
  logic [N-1:0][DATA_WIDTH-1:0]   a_head, b_head;
  logic [N-1:0][ACC_WIDTH-1:0]    acc_grid [N];
  logic [DATA_WIDTH-1:0]          a_h [N][N];   // operand entering PE(i,j) from the left
  logic [DATA_WIDTH-1:0]          b_v [N][N];   // operand entering PE(i,j) from above
  logic [DATA_WIDTH-1:0]          a_unused [N], b_unused [N];
  logic                           a_hs, b_hs, pe_en, pe_clr;

  assign a_hs   = a_valid & a_ready;
  assign b_hs   = b_valid & b_ready;
  assign pe_en  = (state_q == ST_COMPUTE);
  assign pe_clr = pe_en && (cc_q == '0) && !acc_mode_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start) state_d = ST_LOAD;
      ST_LOAD:    if (a_cnt_d == N_CNT && b_cnt_d == N_CNT) state_d = ST_COMPUTE;
      ST_COMPUTE: if (cc_q == CC_LAST) state_d = ST_DRAIN;
      ST_DRAIN:   if (c_ready && row_q == ROW_LAST) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready   = (state_q == ST_IDLE);
    done    = (state_q == ST_DONE);
    a_ready = (state_q == ST_LOAD) && (a_cnt_q != N_CNT);
    b_ready = (state_q == ST_LOAD) && (b_cnt_q != N_CNT);
    c_valid = (state_q == ST_DRAIN);
    c_row   = row_q;
    c_out   = acc_grid[row_q];
  end

  // Counters, mode latches and operand buffers
  always_comb begin
    a_cnt_d       = a_cnt_q;
    b_cnt_d       = b_cnt_q;
    cc_d          = '0;
    row_d         = row_q;
    acc_mode_d    = acc_mode_q;
    signed_mode_d = signed_mode_q;
    a_buf_d       = a_buf_q;
    b_buf_d       = b_buf_q;
    if (state_q == ST_IDLE && start) begin
      a_cnt_d       = '0;
      b_cnt_d       = '0;
      acc_mode_d    = acc_mode;
      signed_mode_d = signed_mode;
    end
    if (a_hs) begin
      for (int e = 0; e < N; e++) if (a_cnt_q == CW'(e)) a_buf_d[e] = a_in;
      a_cnt_d = a_cnt_q + CW'(1);
    end
    if (b_hs) begin
      for (int e = 0; e < N; e++) if (b_cnt_q == CW'(e)) b_buf_d[e] = b_in;
      b_cnt_d = b_cnt_q + CW'(1);
    end
    if (state_q == ST_COMPUTE) cc_d = cc_q + CCW'(1);
    if (state_q == ST_DRAIN && c_ready) row_d = (row_q == ROW_LAST) ? '0 : row_q + IW'(1);
  end

  // Beat k is presented to the array edge on compute cycle k; zeros otherwise.
  always_comb begin
    a_head = '0;
    b_head = '0;
    if (state_q == ST_COMPUTE) begin
      for (int e = 0; e < N; e++) begin
        if (cc_q == CCW'(e)) begin
          a_head = a_buf_q[e];
          b_head = b_buf_q[e];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_cnt_q       <= '0;
      b_cnt_q       <= '0;
      cc_q          <= '0;
      row_q         <= '0;
      acc_mode_q    <= 1'b0;
      signed_mode_q <= 1'b0;
      a_buf_q       <= '{default: '0};
      b_buf_q       <= '{default: '0};
    end else begin
      a_cnt_q       <= a_cnt_d;
      b_cnt_q       <= b_cnt_d;
      cc_q          <= cc_d;
      row_q         <= row_d;
      acc_mode_q    <= acc_mode_d;
      signed_mode_q <= signed_mode_d;
      a_buf_q       <= a_buf_d;
      b_buf_q       <= b_buf_d;
    end
  end

  // Skew: row i of A and column i of B are delayed by i cycles so that
  // A[i][k] and B[k][j] meet in PE(i,j) on compute cycle k+i+j.
  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_h[0][0] = a_head[0];
      assign b_v[0][0] = b_head[0];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] a_dly_q [i], a_dly_d [i];
      logic [DATA_WIDTH-1:0] b_dly_q [i], b_dly_d [i];
      always_comb begin
        a_dly_d[0] = a_head[i];
        b_dly_d[0] = b_head[i];
        for (int s = 1; s < i; s++) begin
          a_dly_d[s] = a_dly_q[s-1];
          b_dly_d[s] = b_dly_q[s-1];
        end
      end
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          a_dly_q <= '{default: '0};
          b_dly_q <= '{default: '0};
        end else begin
          a_dly_q <= a_dly_d;
          b_dly_q <= b_dly_d;
        end
      end
      assign a_h[i][0] = a_dly_q[i-1];
      assign b_v[0][i] = b_dly_q[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DATA_WIDTH-1:0] a_nx, b_nx;
      systolic_pe #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clk        (clk),
        .rst        (rst),
        .en         (pe_en),
        .clr        (pe_clr),
        .signed_mode(signed_mode_q),
        .a_in       (a_h[i][j]),
        .b_in       (b_v[i][j]),
        .a_out      (a_nx),
        .b_out      (b_nx),
        .acc_out    (acc_grid[i][j])
      );
      if (j < N-1) begin : g_a_fwd
        assign a_h[i][j+1] = a_nx;
      end else begin : g_a_end
        assign a_unused[i] = a_nx;
      end
      if (i < N-1) begin : g_b_fwd
        assign b_v[i+1][j] = b_nx;
      end else begin : g_b_end
        assign b_unused[j] = b_nx;
      end
    end
  end

endmodule
